// File: rtl/lcd_sched_pkg.sv
// Shared types for the LCD update scheduler: FSM states and the queued instruction record.
package lcd_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_HOLD
  } state_t;

  // 'reg' is a keyword, hence reg_idx.
  typedef struct packed {
    logic [2:0]  opcode;
    logic [3:0]  reg_idx;
    logic [15:0] value;
  } record_t;

  localparam logic [2:0] OPC_CLEAR = 3'b110;

endpackage

// File: rtl/lcd_req_fifo.sv
// Synchronous request FIFO with flush; under LCD_SCHED_COALESCE_EN it also exposes
// the newest entry and an in-place overwrite port for it.
module lcd_req_fifo
  import lcd_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
`ifdef LCD_SCHED_COALESCE_EN
  input  logic                     i_ovw,
  output record_t                  o_newest,
`endif
  input  record_t                  i_wdata,
  output record_t                  o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);

  record_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;
  logic w_do_ovw;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
`ifdef LCD_SCHED_COALESCE_EN
  assign w_do_ovw  = i_ovw && (r_count != '0) && !i_flush;
  assign o_newest  = r_mem[r_wr - 1'b1];
`else
  assign w_do_ovw  = 1'b0;
`endif

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

  // NOTE: storage has no reset; only the pointers and count define validity, so
  // the array can map onto plain RAM/registers without a reset tree.
  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr] <= i_wdata;
    else if (w_do_ovw)
      r_mem[r_wr - 1'b1] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/lcd_update_scheduler.sv
// Queues CPU display updates and issues them one at a time to lcd_controller with a hold time.
// Optional macro LCD_SCHED_COALESCE_EN: a push to the same register as the newest entry overwrites it.
module lcd_update_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 25000000,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [2:0]               req_opcode,
  input  logic [3:0]               req_reg,
  input  logic [15:0]              req_value,
  output logic                     req_ready,
  input  logic                     splash_req,
  input  logic                     blank_req,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     lcd_start_update,
  output logic                     lcd_mode_splash,
  output logic                     lcd_mode_blank,
  output logic [2:0]               lcd_opcode,
  output logic [3:0]               lcd_reg,
  output logic [15:0]              lcd_value,
  input  logic                     lcd_busy,
  output logic                     sched_busy
);

  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pend_blank;
  logic             r_pend_splash;
  logic [HW-1:0]    r_hold;
  logic [TW-1:0]    r_tmo;

  record_t          w_req;
  record_t          w_head;
  record_t          w_sel;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_coalesce;
  logic             w_load;
  logic             w_sel_blank;
  logic             w_sel_splash;

  assign w_req = '{opcode: req_opcode, reg_idx: req_reg, value: req_value};

`ifdef LCD_SCHED_COALESCE_EN
  record_t w_newest;
  // Skip coalescing when the only entry is leaving this cycle; it becomes a normal push.
  assign w_coalesce = req_valid && (fifo_count != '0) && (w_newest.reg_idx == req_reg)
                      && !(w_pop && (fifo_count == 1));
`else
  assign w_coalesce = 1'b0;
`endif

  assign w_push = req_valid && !w_coalesce;

  lcd_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (blank_req),
`ifdef LCD_SCHED_COALESCE_EN
    .i_ovw    (w_coalesce),
    .o_newest (w_newest),
`endif
    .i_wdata  (w_req),
    .o_head   (w_head),
    .o_count  (fifo_count),
    .o_full   (w_full)
  );

  assign req_ready        = !w_full;
  assign lcd_start_update = (r_state == S_ISSUE);
  assign sched_busy       = (r_state != S_IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_sel_blank  = 1'b0;
    w_sel_splash = 1'b0;
    w_sel        = '0;
    unique case (r_state)
      S_IDLE: begin
        if (!lcd_busy) begin
          if (r_pend_blank) begin
            w_sel_blank = 1'b1;
            w_sel       = '{opcode: OPC_CLEAR, reg_idx: 4'd0, value: 16'd0};
            w_load      = 1'b1;
          end else if (r_pend_splash) begin
            w_sel_splash = 1'b1;
            w_load       = 1'b1;
          end else if (fifo_count != '0) begin
            w_pop  = 1'b1;
            w_sel  = w_head;
            w_load = 1'b1;
          end
          if (w_load) w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:     w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (lcd_busy)                          w_state_nxt = S_WAIT_DONE;
        else if (r_tmo == TW'(ACK_TIMEOUT - 1)) w_state_nxt = S_ISSUE;
      end
      S_WAIT_DONE: if (!lcd_busy)     w_state_nxt = S_HOLD;
      S_HOLD:      if (r_hold == '0)  w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_pend_blank    <= 1'b0;
      r_pend_splash   <= 1'b0;
      r_hold          <= '0;
      r_tmo           <= '0;
      overflow        <= 1'b0;
      lcd_mode_splash <= 1'b0;
      lcd_mode_blank  <= 1'b0;
      lcd_opcode      <= '0;
      lcd_reg         <= '0;
      lcd_value       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      // A new request in the cycle its flag is consumed re-arms the flag.
      r_pend_blank  <= (r_pend_blank && !w_sel_blank) || blank_req;
      r_pend_splash <= (r_pend_splash && !w_sel_splash) || splash_req;
      overflow      <= req_valid && w_full && !w_coalesce && !blank_req;

      if (r_state == S_ISSUE)         r_tmo <= '0;
      else if (r_state == S_WAIT_ACK) r_tmo <= r_tmo + 1'b1;

      if (r_state == S_WAIT_DONE && !lcd_busy) r_hold <= HW'(HOLD_CYCLES);
      else if (r_state == S_HOLD && r_hold != '0) r_hold <= r_hold - 1'b1;

      if (w_load) begin
        lcd_mode_blank  <= w_sel_blank;
        lcd_mode_splash <= w_sel_splash;
        lcd_opcode      <= w_sel.opcode;
        lcd_reg         <= w_sel.reg_idx;
        lcd_value       <= w_sel.value;
      end
    end
  end

endmodule

// File: tb/tb_lcd_update_scheduler.sv
// Directed bench for lcd_update_scheduler with a simple lcd_controller busy model.
module tb_lcd_update_scheduler;

  localparam int DEPTH       = 4;
  localparam int HOLD_CYCLES = 4;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_opcode;
  logic [3:0]  req_reg;
  logic [15:0] req_value;
  logic        req_ready;
  logic        splash_req;
  logic        blank_req;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        lcd_start_update;
  logic        lcd_mode_splash;
  logic        lcd_mode_blank;
  logic [2:0]  lcd_opcode;
  logic [3:0]  lcd_reg;
  logic [15:0] lcd_value;
  logic        lcd_busy;
  logic        sched_busy;

  lcd_update_scheduler #(
    .DEPTH(DEPTH), .HOLD_CYCLES(HOLD_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_opcode(req_opcode), .req_reg(req_reg), .req_value(req_value),
    .req_ready(req_ready), .splash_req(splash_req), .blank_req(blank_req),
    .fifo_count(fifo_count), .overflow(overflow),
    .lcd_start_update(lcd_start_update), .lcd_mode_splash(lcd_mode_splash),
    .lcd_mode_blank(lcd_mode_blank), .lcd_opcode(lcd_opcode), .lcd_reg(lcd_reg),
    .lcd_value(lcd_value), .lcd_busy(lcd_busy), .sched_busy(sched_busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        splash;
    logic        blank;
    logic [2:0]  op;
    logic [3:0]  rg;
    logic [15:0] val;
  } start_t;

  start_t starts[$];
  int     falls[$];
  int     cyc = 0;
  int     busy_cnt = 0;
  int     ignored = 0;
  int     ignore_budget = 0;
  logic   model_busy = 1'b0;
  logic   stall;

  int n_checks = 0;
  int n_errors = 0;

  assign lcd_busy = stall | model_busy;

  // LCD model: acks a start immediately and stays busy for 10 cycles; can drop starts.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      busy_cnt   = 0;
      model_busy = 1'b0;
    end else if (lcd_start_update) begin
      starts.push_back('{cyc, lcd_mode_splash, lcd_mode_blank, lcd_opcode, lcd_reg, lcd_value});
      if (ignored < ignore_budget) begin
        ignored++;
      end else begin
        busy_cnt   = 10;
        model_busy = 1'b1;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        model_busy = 1'b0;
        falls.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] rg, input logic [15:0] v);
    req_valid  = 1'b1;
    req_opcode = op;
    req_reg    = rg;
    req_value  = v;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 2000) begin
      step();
      n++;
      if (!sched_busy && fifo_count == 0 && !lcd_busy) quiet++;
      else quiet = 0;
    end
    check(tag, quiet, 3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int f0;
    logic [2:0]  exp_op  [3];
    logic [3:0]  exp_rg  [3];
    logic [15:0] exp_val [3];

    rst = 1'b1; stall = 1'b1;
    req_valid = 1'b0; req_opcode = '0; req_reg = '0; req_value = '0;
    splash_req = 1'b0; blank_req = 1'b0;
    step(3);
    check("rst_lcd_out", {lcd_start_update, lcd_mode_splash, lcd_mode_blank, lcd_opcode, lcd_reg, lcd_value}, 0);
    check("rst_ready", req_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_sched_busy", sched_busy, 0);

    // LCD busy after reset: nothing may start until busy drops.
    rst = 1'b0;
    step(50);
    push(3'b001, 4'b0011, 16'd42);
    check("init_count", fifo_count, 1);
    n0 = starts.size();
    step(50);
    check("init_no_start", starts.size() - n0, 0);
    check("init_idle", sched_busy, 0);
    stall = 1'b0;
    step();
    check("init_start", lcd_start_update, 1);
    check("init_data", {lcd_mode_splash, lcd_mode_blank, lcd_opcode, lcd_reg, lcd_value},
          {2'b00, 3'b001, 4'b0011, 16'd42});
    check("init_popped", fifo_count, 0);
    step();
    check("start_one_cycle", lcd_start_update, 0);
    wait_idle("init_done");
    check("init_one_start", starts.size() - n0, 1);

    // Push into empty FIFO with idle LCD: start two edges after the push edge.
    push(3'b010, 4'h1, 16'h0005);
    check("lat_edge1", lcd_start_update, 0);
    step();
    check("lat_edge2", lcd_start_update, 1);
    wait_idle("lat_done");

    // Three records: FIFO order and hold spacing after busy falls.
    exp_op[0] = 3'b011; exp_rg[0] = 4'h2; exp_val[0] = 16'd100;
    exp_op[1] = 3'b100; exp_rg[1] = 4'h7; exp_val[1] = 16'hFFFF;
    exp_op[2] = 3'b101; exp_rg[2] = 4'hF; exp_val[2] = 16'h8000;
    n0 = starts.size();
    f0 = falls.size();
    for (int i = 0; i < 3; i++) push(exp_op[i], exp_rg[i], exp_val[i]);
    wait_idle("seq_done");
    check("seq_starts", starts.size() - n0, 3);
    if (starts.size() >= n0 + 3 && falls.size() >= f0 + 2) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("seq_data%0d", i),
              {starts[n0+i].splash, starts[n0+i].blank, starts[n0+i].op, starts[n0+i].rg, starts[n0+i].val},
              {2'b00, exp_op[i], exp_rg[i], exp_val[i]});
      for (int i = 1; i < 3; i++)
        check($sformatf("seq_hold_gap%0d", i),
              ((starts[n0+i].cyc - falls[f0+i-1] - 1) >= HOLD_CYCLES) ? 1 : 0, 1);
    end

    // Queued records then splash+blank together: flush, blank first, splash second.
    stall = 1'b1;
    push(3'b001, 4'h1, 16'd1);
    push(3'b001, 4'h2, 16'd2);
    check("pend_count2", fifo_count, 2);
    splash_req = 1'b1; blank_req = 1'b1;
    step();
    splash_req = 1'b0; blank_req = 1'b0;
    check("pend_flushed", fifo_count, 0);
    n0 = starts.size();
    stall = 1'b0;
    wait_idle("pend_done");
    check("pend_starts", starts.size() - n0, 2);
    if (starts.size() >= n0 + 2) begin
      check("pend_first_blank", {starts[n0].splash, starts[n0].blank}, 2'b01);
      check("pend_second_splash", {starts[n0+1].splash, starts[n0+1].blank}, 2'b10);
    end

    // Overflow at DEPTH, then flush with a simultaneous push.
    stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(3'b001, 4'(i), 16'(i));
    check("full_ready", req_ready, 0);
    check("full_count", fifo_count, 4);
    check("full_no_ovf", overflow, 0);
    push(3'b001, 4'h9, 16'h0009);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", fifo_count, 4);
    step();
    check("ovf_one_cycle", overflow, 0);
    req_valid = 1'b1; req_reg = 4'hA; blank_req = 1'b1;
    step();
    req_valid = 1'b0; blank_req = 1'b0;
    check("flush_push_count", fifo_count, 0);
    check("flush_push_no_ovf", overflow, 0);
    check("flush_ready", req_ready, 1);
    n0 = starts.size();
    stall = 1'b0;
    wait_idle("flush_done");
    check("flush_starts", starts.size() - n0, 1);
    if (starts.size() >= n0 + 1)
      check("flush_blank", {starts[n0].splash, starts[n0].blank}, 2'b01);

    // First start ignored: retry after the ack timeout with identical outputs.
    ignore_budget = 1;
    n0 = starts.size();
    push(3'b111, 4'h9, 16'h1234);
    wait_idle("retry_done");
    check("retry_starts", starts.size() - n0, 2);
    if (starts.size() >= n0 + 2) begin
      check("retry_data0", {starts[n0].splash, starts[n0].blank, starts[n0].op, starts[n0].rg, starts[n0].val},
            {2'b00, 3'b111, 4'h9, 16'h1234});
      check("retry_data1", {starts[n0+1].splash, starts[n0+1].blank, starts[n0+1].op, starts[n0+1].rg, starts[n0+1].val},
            {2'b00, 3'b111, 4'h9, 16'h1234});
      // Issue cycle, then ACK_TIMEOUT cycles waiting, then the re-issue.
      check("retry_gap", starts[n0+1].cyc - starts[n0].cyc, ACK_TIMEOUT + 1);
    end

    // Same register pushed twice while stalled.
    stall = 1'b1;
    push(3'b001, 4'h5, 16'd1);
    push(3'b001, 4'h5, 16'hFFF9);
`ifdef LCD_SCHED_COALESCE_EN
    check("coal_count", fifo_count, 1);
`else
    check("coal_count", fifo_count, 2);
`endif
    n0 = starts.size();
    stall = 1'b0;
    wait_idle("coal_done");
`ifdef LCD_SCHED_COALESCE_EN
    check("coal_starts", starts.size() - n0, 1);
    if (starts.size() >= n0 + 1) check("coal_value", starts[n0].val, 16'hFFF9);
`else
    check("coal_starts", starts.size() - n0, 2);
    if (starts.size() >= n0 + 2) begin
      check("coal_value0", starts[n0].val, 16'h0001);
      check("coal_value1", starts[n0+1].val, 16'hFFF9);
    end
`endif

    // Reset mid-operation returns everything to reset values.
    push(3'b011, 4'h3, 16'd3);
    step();
    rst = 1'b1;
    #1;
    check("midrst_sched_busy", sched_busy, 0);
    check("midrst_lcd_out", {lcd_start_update, lcd_mode_splash, lcd_mode_blank, lcd_opcode, lcd_reg, lcd_value}, 0);
    check("midrst_count", fifo_count, 0);
    step(2);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
